// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// =============================================================================
// Module   : ex_muldiv_pkg
// Purpose  : Shared encodings for the EX-stage multiply/divide unit: operation
//            codes, FSM state codes and the ALU-select to operation mapping
//            used by the EX decode.
// Ports    : none (package)
// Revision : 1.0 - initial release
// =============================================================================
package ex_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // ALU-select codes of the mul/div group; the low two bits are the op code.
  localparam logic [3:0] c_ALU_SEL_MULT  = 4'hC;
  localparam logic [3:0] c_ALU_SEL_MULTU = 4'hD;
  localparam logic [3:0] c_ALU_SEL_DIV   = 4'hE;
  localparam logic [3:0] c_ALU_SEL_DIVU  = 4'hF;

  function automatic logic alu_sel_is_muldiv(input logic [3:0] sel);
    return sel[3:2] == 2'b11;
  endfunction

  function automatic md_op_e alu_sel_to_op(input logic [3:0] sel);
    return md_op_e'(sel[1:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_if.sv
`default_nettype none
// =============================================================================
// Module   : ex_muldiv_if
// Purpose  : Request/result bundle between the EX stage (master) and the
//            multiply/divide unit (slave).
// Signals  : start, op[1:0], src_a, src_b, flush, hold   (EX -> unit)
//            stall_req, busy, done, hi, lo               (unit -> EX)
// Revision : 1.0 - initial release
// =============================================================================
interface ex_muldiv_if #(
  parameter int W = 32
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         flush;
  logic         hold;
  logic         stall_req;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush, hold,
    input  stall_req, busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hold,
    output stall_req, busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_core.sv
`default_nettype none
// =============================================================================
// Module   : ex_muldiv_core
// Purpose  : Iteration datapath of the mul/div unit. Unsigned shift-add
//            multiply and restoring shift-subtract divide on magnitudes,
//            one iteration per step, ITER steps per operation.
// Ports    : clk, rst (async, active-low)
//            init    - load magnitudes, clear counter
//            step    - perform one iteration
//            is_div  - select divide (1) or multiply (0) iteration
//            a_mag   - multiplier / dividend magnitude
//            b_mag   - multiplicand / divisor magnitude
//            last    - counter is at the final iteration
//            prod    - 2*ITER-bit product magnitude
//            quot    - quotient magnitude
//            rem     - remainder magnitude
// Revision : 1.0 - initial release
// =============================================================================
module ex_muldiv_core #(
  parameter int ITER = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              step,
  input  logic              is_div,
  input  logic [ITER-1:0]   a_mag,
  input  logic [ITER-1:0]   b_mag,
  output logic              last,
  output logic [2*ITER-1:0] prod,
  output logic [ITER-1:0]   quot,
  output logic [ITER-1:0]   rem
);
  localparam int            CW     = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(ITER - 1);

  logic [CW-1:0]     r_cnt;
  logic [ITER-1:0]   r_b;
  logic [2*ITER-1:0] r_prod;   // {partial product high, unconsumed multiplier}
  logic [ITER-1:0]   r_quot;   // dividend bits shift out, quotient bits shift in
  logic [ITER:0]     r_rem;
  logic [ITER:0]     w_add;
  logic [ITER+1:0]   w_diff;
  logic              w_ge;

  assign w_add  = {1'b0, r_prod[2*ITER-1:ITER]}
                + (r_prod[0] ? {1'b0, r_b} : {(ITER+1){1'b0}});
  // Trial subtract of the divisor from the partial remainder with the next
  // dividend bit shifted in; one extra bit keeps the borrow visible.
  assign w_diff = {1'b0, r_rem[ITER-1:0], r_quot[ITER-1]} - {2'b00, r_b};
  assign w_ge   = r_rem[ITER] | ~w_diff[ITER+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_b    <= '0;
      r_prod <= '0;
      r_quot <= '0;
      r_rem  <= '0;
    end else if (init) begin
      r_cnt  <= '0;
      r_b    <= b_mag;
      r_prod <= {{ITER{1'b0}}, a_mag};
      r_quot <= a_mag;
      r_rem  <= '0;
    end else if (step) begin
      r_cnt <= r_cnt + CW'(1);
      if (is_div) begin
        r_quot <= {r_quot[ITER-2:0], w_ge};
        r_rem  <= w_ge ? w_diff[ITER:0] : {r_rem[ITER-1:0], r_quot[ITER-1]};
      end else begin
        r_prod <= {w_add, r_prod[ITER-1:1]};
      end
    end
  end

  assign last = (r_cnt == c_LAST);
  assign prod = r_prod;
  assign quot = r_quot;
  assign rem  = r_rem[ITER-1:0];
endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// =============================================================================
// Module   : ex_muldiv
// Purpose  : EX-stage iterative multiply/divide unit (MULT/MULTU/DIV/DIVU).
//            Owns the control FSM, sign handling, result fixup and the HI/LO
//            output registers; iterations run in ex_muldiv_core.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous, active-low reset
//            bus  - ex_muldiv_if.slave (start/op/src_a/src_b/flush/hold in,
//                   stall_req/busy/done/hi/lo out)
// Config   : MULDIV_FAST_MUL_EN - single-cycle multiply, skips CALC.
// Revision : 1.0 - initial release
// =============================================================================
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);
  md_state_e         r_state;
  md_state_e         w_next;
  logic              w_signed;
  logic              w_accept;
  logic              w_last;
  logic              w_fast;
  logic [ITER-1:0]   w_a_mag;
  logic [ITER-1:0]   w_b_mag;
  logic [2*ITER-1:0] w_prod;
  logic [ITER-1:0]   w_quot;
  logic [ITER-1:0]   w_rem;
  logic              r_is_div;
  logic              r_neg_res;   // product / quotient must be negated
  logic              r_neg_rem;   // remainder takes the dividend sign
  logic              r_div0;
  logic [ITER-1:0]   r_hi;
  logic [ITER-1:0]   r_lo;

  assign w_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);
  assign w_a_mag  = (w_signed && bus.src_a[ITER-1]) ? -bus.src_a : bus.src_a;
  assign w_b_mag  = (w_signed && bus.src_b[ITER-1]) ? -bus.src_b : bus.src_b;
  assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.flush;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*ITER+1:0] w_fast_full;
  logic [2*ITER-1:0]        r_fast_prod;

  assign w_fast      = (bus.op == MD_MULT) || (bus.op == MD_MULTU);
  // One extension bit lets the same signed multiplier serve MULT and MULTU.
  assign w_fast_full = $signed({w_signed & bus.src_a[ITER-1], bus.src_a})
                     * $signed({w_signed & bus.src_b[ITER-1], bus.src_b});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_fast_prod <= '0;
    else if (w_accept) r_fast_prod <= w_fast_full[2*ITER-1:0];
  end
`else
  assign w_fast = 1'b0;
`endif

  ex_muldiv_core #(.ITER(ITER)) u_core (
    .clk    (clk),
    .rst    (rst),
    .init   (w_accept),
    .step   (r_state == ST_CALC),
    .is_div (r_is_div),
    .a_mag  (w_a_mag),
    .b_mag  (w_b_mag),
    .last   (w_last),
    .prod   (w_prod),
    .quot   (w_quot),
    .rem    (w_rem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.stall_req = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    unique case (r_state)
      ST_IDLE: if (bus.start) w_next = w_fast ? ST_FIX : ST_CALC;
      ST_CALC: if (w_last) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: if (!bus.hold) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (bus.flush) w_next = ST_IDLE;
    // Gated by rst so an asserted start cannot stall the pipe during reset.
    bus.stall_req = rst && (w_accept || (r_state == ST_CALC) || (r_state == ST_FIX));
    bus.busy      = (r_state != ST_IDLE);
    bus.done      = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      if (w_accept) begin
        r_is_div  <= (bus.op == MD_DIV) || (bus.op == MD_DIVU);
        r_neg_res <= w_signed && (bus.src_a[ITER-1] ^ bus.src_b[ITER-1]);
        r_neg_rem <= w_signed && bus.src_a[ITER-1];
        r_div0    <= (bus.src_b == '0);
      end
      if ((r_state == ST_FIX) && !bus.flush) begin
        if (r_is_div) begin
          // Divide by zero yields an all-ones quotient and the raw dividend;
          // re-applying the dividend sign to |a| restores the raw value.
          r_lo <= (r_neg_res && !r_div0) ? -w_quot : w_quot;
          r_hi <= r_neg_rem ? -w_rem : w_rem;
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          {r_hi, r_lo} <= r_fast_prod;
`else
          {r_hi, r_lo} <= r_neg_res ? -w_prod : w_prod;
`endif
        end
      end
    end
  end

  assign bus.hi = r_hi;
  assign bus.lo = r_lo;
endmodule
`default_nettype wire
